// File: rtl/mdu_sequencer.sv
// RV32M sequencer: operand sign pre-transform, mul/div engine handshakes, sign post-correction, fast paths.
// Optional one-entry result cache enabled by defining MDU_RESULT_CACHE_EN.
module mdu_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              req_valid_in,
  input  logic [2:0]        funct3_in,
  input  logic [XLEN-1:0]   op1_in,
  input  logic [XLEN-1:0]   op2_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              flush_in,
  output logic              stall_out,
  output logic              mul_req_out,
  output logic [XLEN-1:0]   mul_a_out,
  output logic [XLEN-1:0]   mul_b_out,
  input  logic              mul_ready_in,
  input  logic [2*XLEN-1:0] mul_result_in,
  output logic              div_req_out,
  output logic [XLEN-1:0]   div_a_out,
  output logic [XLEN-1:0]   div_b_out,
  output logic              div_is_q_out,
  input  logic              div_ready_in,
  input  logic [XLEN-1:0]   div_result_in,
  output logic              reg_we_out,
  output logic [RD_W-1:0]   reg_waddr_out,
  output logic [XLEN-1:0]   reg_wdata_out
);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t          state;
  logic [2:0]      f3;
  logic            a_neg;
  logic            b_neg;
  logic            we_q;

  logic            sgn_a_c;
  logic            sgn_b_c;
  logic [XLEN-1:0] op_a_c;
  logic [XLEN-1:0] op_b_c;
  logic            fast_c;
  logic [XLEN-1:0] fast_data_c;
  logic [PW-1:0]   prod_neg_c;
  logic [XLEN-1:0] div_neg_c;
  logic [XLEN-1:0] post_c;
  logic            hit_c;
  logic [XLEN-1:0] hit_data_c;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? XLEN'(~x + XLEN'(1)) : x;
  endfunction

  // Operand pre-transform and divide fast-path detection for the op presented in IDLE
  always_comb begin
    sgn_a_c = 1'b0;
    sgn_b_c = 1'b0;
    case (funct3_in)
      3'd1, 3'd4, 3'd6: begin sgn_a_c = 1'b1; sgn_b_c = 1'b1; end
      3'd2:             sgn_a_c = 1'b1;
      default:          ;
    endcase
    op_a_c = sgn_a_c ? mag(op1_in) : op1_in;
    op_b_c = sgn_b_c ? mag(op2_in) : op2_in;
    fast_c      = 1'b0;
    fast_data_c = '0;
    if (funct3_in[2] && op2_in == '0) begin
      fast_c      = 1'b1;
      fast_data_c = funct3_in[1] ? op1_in : '1;
    end else if (funct3_in[2] && !funct3_in[0] && op2_in == '1 &&
                 op1_in == {1'b1, {(XLEN-1){1'b0}}}) begin
      fast_c      = 1'b1;
      fast_data_c = funct3_in[1] ? '0 : op1_in;
    end
  end

  // Sign post-correction of the engine result, keyed by the latched funct3
  always_comb begin
    prod_neg_c = ~mul_result_in + PW'(1);
    div_neg_c  = ~div_result_in + XLEN'(1);
    case (f3)
      3'd0:    post_c = mul_result_in[XLEN-1:0];
      3'd1:    post_c = (a_neg ^ b_neg) ? prod_neg_c[PW-1:XLEN] : mul_result_in[PW-1:XLEN];
      3'd2:    post_c = a_neg ? prod_neg_c[PW-1:XLEN] : mul_result_in[PW-1:XLEN];
      3'd3:    post_c = mul_result_in[PW-1:XLEN];
      3'd4:    post_c = (a_neg ^ b_neg) ? div_neg_c : div_result_in;
      3'd6:    post_c = a_neg ? div_neg_c : div_result_in;
      default: post_c = div_result_in;
    endcase
  end

`ifdef MDU_RESULT_CACHE_EN
  logic            c_valid;
  logic [2:0]      c_f3;
  logic [XLEN-1:0] c_op1;
  logic [XLEN-1:0] c_op2;
  logic [XLEN-1:0] c_res;
  logic [XLEN-1:0] p_op1;
  logic [XLEN-1:0] p_op2;
  assign hit_c = c_valid && c_f3 == funct3_in && c_op1 == op1_in && c_op2 == op2_in;
  assign hit_data_c = c_res;
`else
  assign hit_c      = 1'b0;
  assign hit_data_c = '0;
`endif

  assign stall_out  = (req_valid_in && state == IDLE) || state == MUL_WAIT || state == DIV_WAIT;
  assign reg_we_out = we_q && !flush_in;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state         <= IDLE;
      f3            <= '0;
      a_neg         <= 1'b0;
      b_neg         <= 1'b0;
      we_q          <= 1'b0;
      mul_req_out   <= 1'b0;
      mul_a_out     <= '0;
      mul_b_out     <= '0;
      div_req_out   <= 1'b0;
      div_a_out     <= '0;
      div_b_out     <= '0;
      div_is_q_out  <= 1'b0;
      reg_waddr_out <= '0;
      reg_wdata_out <= '0;
`ifdef MDU_RESULT_CACHE_EN
      c_valid <= 1'b0;
      c_f3    <= '0;
      c_op1   <= '0;
      c_op2   <= '0;
      c_res   <= '0;
      p_op1   <= '0;
      p_op2   <= '0;
`endif
    end else if (flush_in) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      mul_req_out <= 1'b0;
      div_req_out <= 1'b0;
`ifdef MDU_RESULT_CACHE_EN
      c_valid <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state)
        IDLE: if (req_valid_in) begin
          f3            <= funct3_in;
          a_neg         <= op1_in[XLEN-1];
          b_neg         <= op2_in[XLEN-1];
          reg_waddr_out <= rd_in;
`ifdef MDU_RESULT_CACHE_EN
          p_op1 <= op1_in;
          p_op2 <= op2_in;
`endif
          if (fast_c) begin
            state         <= DONE;
            we_q          <= 1'b1;
            reg_wdata_out <= fast_data_c;
          end else if (hit_c) begin
            state         <= DONE;
            we_q          <= 1'b1;
            reg_wdata_out <= hit_data_c;
          end else if (funct3_in[2]) begin
            state        <= DIV_WAIT;
            div_req_out  <= 1'b1;
            div_a_out    <= op_a_c;
            div_b_out    <= op_b_c;
            div_is_q_out <= !funct3_in[1];
          end else begin
            state       <= MUL_WAIT;
            mul_req_out <= 1'b1;
            mul_a_out   <= op_a_c;
            mul_b_out   <= op_b_c;
          end
        end
        MUL_WAIT, DIV_WAIT: begin
          if ((state == MUL_WAIT && mul_ready_in) || (state == DIV_WAIT && div_ready_in)) begin
            state         <= DONE;
            mul_req_out   <= 1'b0;
            div_req_out   <= 1'b0;
            we_q          <= 1'b1;
            reg_wdata_out <= post_c;
`ifdef MDU_RESULT_CACHE_EN
            c_valid <= 1'b1;
            c_f3    <= f3;
            c_op1   <= p_op1;
            c_op2   <= p_op2;
            c_res   <= post_c;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer; engines are modelled by driving ready/result by hand.
module tb_mdu_sequencer;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic [2:0]        funct3 = '0;
  logic [XLEN-1:0]   op1 = '0;
  logic [XLEN-1:0]   op2 = '0;
  logic [RD_W-1:0]   rd = '0;
  logic              flush = 1'b0;
  logic              stall;
  logic              mul_req;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic              mul_ready = 1'b0;
  logic [2*XLEN-1:0] mul_result = '0;
  logic              div_req;
  logic [XLEN-1:0]   div_a;
  logic [XLEN-1:0]   div_b;
  logic              div_is_q;
  logic              div_ready = 1'b0;
  logic [XLEN-1:0]   div_result = '0;
  logic              reg_we;
  logic [RD_W-1:0]   reg_waddr;
  logic [XLEN-1:0]   reg_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_sequencer #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk_in(clk), .reset_in(reset), .req_valid_in(req_valid), .funct3_in(funct3),
    .op1_in(op1), .op2_in(op2), .rd_in(rd), .flush_in(flush), .stall_out(stall),
    .mul_req_out(mul_req), .mul_a_out(mul_a), .mul_b_out(mul_b),
    .mul_ready_in(mul_ready), .mul_result_in(mul_result),
    .div_req_out(div_req), .div_a_out(div_a), .div_b_out(div_b), .div_is_q_out(div_is_q),
    .div_ready_in(div_ready), .div_result_in(div_result),
    .reg_we_out(reg_we), .reg_waddr_out(reg_waddr), .reg_wdata_out(reg_wdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine op: accept, hold req for two cycles, return eng_res, expect one writeback of data
  task automatic engine_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] r, input logic [31:0] ea,
                           input logic [31:0] eb, input logic eq, input logic [63:0] eng_res,
                           input logic [31:0] data);
    logic is_mul;
    is_mul = !f[2];
    @(negedge clk);
    req_valid = 1'b1; funct3 = f; op1 = a; op2 = b; rd = r;
    #1;
    check({tag, "_stall_acc"}, 64'(stall), 64'd1);
    check({tag, "_req_c0"}, 64'(mul_req | div_req), 64'd0);
    @(negedge clk);
    check({tag, "_mreq"}, 64'(mul_req), 64'(is_mul));
    check({tag, "_dreq"}, 64'(div_req), 64'(!is_mul));
    check({tag, "_a"}, is_mul ? 64'(mul_a) : 64'(div_a), 64'(ea));
    check({tag, "_b"}, is_mul ? 64'(mul_b) : 64'(div_b), 64'(eb));
    if (!is_mul) check({tag, "_isq"}, 64'(div_is_q), 64'(eq));
    req_valid = 1'b0; funct3 = f ^ 3'b011; op1 = ~a; op2 = ~b;
    @(negedge clk);
    check({tag, "_hold"}, 64'(mul_req | div_req), 64'd1);
    check({tag, "_stall_wait"}, 64'(stall), 64'd1);
    check({tag, "_we_wait"}, 64'(reg_we), 64'd0);
    if (is_mul) begin mul_ready = 1'b1; mul_result = eng_res; end
    else begin div_ready = 1'b1; div_result = eng_res[31:0]; end
    @(negedge clk);
    check({tag, "_we"}, 64'(reg_we), 64'd1);
    check({tag, "_waddr"}, 64'(reg_waddr), 64'(r));
    check({tag, "_wdata"}, 64'(reg_wdata), 64'(data));
    check({tag, "_stall_done"}, 64'(stall), 64'd0);
    check({tag, "_req_done"}, 64'(mul_req | div_req), 64'd0);
    mul_ready = 1'b0; div_ready = 1'b0; mul_result = '0; div_result = '0;
    @(negedge clk);
    check({tag, "_we_off"}, 64'(reg_we), 64'd0);
    check({tag, "_wdata_hold"}, 64'(reg_wdata), 64'(data));
  endtask

  // Op completing one cycle after acceptance without any engine request
  task automatic quick_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input logic [31:0] data);
    @(negedge clk);
    req_valid = 1'b1; funct3 = f; op1 = a; op2 = b; rd = r;
    #1;
    check({tag, "_stall_acc"}, 64'(stall), 64'd1);
    @(negedge clk);
    check({tag, "_we"}, 64'(reg_we), 64'd1);
    check({tag, "_waddr"}, 64'(reg_waddr), 64'(r));
    check({tag, "_wdata"}, 64'(reg_wdata), 64'(data));
    check({tag, "_noreq"}, 64'(mul_req | div_req), 64'd0);
    check({tag, "_stall_done"}, 64'(stall), 64'd0);
    req_valid = 1'b0;
    @(negedge clk);
    check({tag, "_we_off"}, 64'(reg_we), 64'd0);
    check({tag, "_noreq2"}, 64'(mul_req | div_req), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_mreq", 64'(mul_req), 64'd0);
    check("rst_dreq", 64'(div_req), 64'd0);
    check("rst_we", 64'(reg_we), 64'd0);
    check("rst_wdata", 64'(reg_wdata), 64'd0);
    check("rst_ma", 64'(mul_a), 64'd0);
    reset = 1'b0;

    engine_op("mul", 3'd0, 32'd7, 32'd6, 5'd3, 32'd7, 32'd6, 1'b0, 64'd42, 32'd42);
    engine_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'd1, 32'd2, 1'b0,
              64'd2, 32'hFFFF_FFFF);
    engine_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'hFFFF_FFFF, 32'd2, 1'b0,
              64'h1_FFFF_FFFE, 32'd1);
    engine_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'd1, 32'hFFFF_FFFF,
              1'b0, 64'h0000_0000_FFFF_FFFF, 32'hFFFF_FFFF);
    engine_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'd7, 32'd2, 1'b1,
              64'd3, 32'hFFFF_FFFD);
    engine_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'd7, 32'd2, 1'b0,
              64'd1, 32'hFFFF_FFFF);
    engine_op("divu", 3'd5, 32'd20, 32'd3, 5'd9, 32'd20, 32'd3, 1'b1, 64'd6, 32'd6);
    engine_op("remu", 3'd7, 32'd20, 32'd3, 5'd10, 32'd20, 32'd3, 1'b0, 64'd2, 32'd2);

    quick_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    quick_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);
    quick_op("divu_z", 3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF);
    quick_op("rem_z", 3'd6, 32'd5, 32'd0, 5'd14, 32'd5);

    // Flush mid-wait: request drops, no writeback, late ready ignored
    @(negedge clk);
    req_valid = 1'b1; funct3 = 3'd4; op1 = 32'hFFFF_FFF9; op2 = 32'd2; rd = 5'd15;
    @(negedge clk);
    req_valid = 1'b0;
    check("fl_dreq_on", 64'(div_req), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_dreq_off", 64'(div_req), 64'd0);
    check("fl_we", 64'(reg_we), 64'd0);
    check("fl_stall", 64'(stall), 64'd0);
    div_ready = 1'b1; div_result = 32'd3;
    @(negedge clk);
    div_ready = 1'b0; div_result = '0;
    check("fl_late_we", 64'(reg_we), 64'd0);
    @(negedge clk);
    check("fl_late_we2", 64'(reg_we), 64'd0);

    // Flush coinciding with acceptance: op is dropped
    req_valid = 1'b1; funct3 = 3'd0; op1 = 32'd5; op2 = 32'd5; rd = 5'd16; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flacc_mreq", 64'(mul_req), 64'd0);
    check("flacc_we", 64'(reg_we), 64'd0);
    @(negedge clk);
    check("flacc_we2", 64'(reg_we), 64'd0);

    engine_op("mul33", 3'd0, 32'd3, 32'd3, 5'd17, 32'd3, 32'd3, 1'b0, 64'd9, 32'd9);

`ifdef MDU_RESULT_CACHE_EN
    engine_op("c_fill", 3'd0, 32'd7, 32'd6, 5'd18, 32'd7, 32'd6, 1'b0, 64'd42, 32'd42);
    quick_op("c_hit", 3'd0, 32'd7, 32'd6, 5'd19, 32'd42);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    engine_op("c_miss", 3'd0, 32'd7, 32'd6, 5'd20, 32'd7, 32'd6, 1'b0, 64'd42, 32'd42);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
